register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning):
- DATA_W, 32, register width in bits; multiple of 8.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled.
- READ_LAT, 0, read latency in cycles; 0 (combinational) or 1 (registered).

REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
- CLK, in, 1, single clock; all state updates on rising edge.
- RST, in, 1, synchronous active-high reset.
- regWriteA, in, 1, write enable, port A.
- destRegA, in, ADDR_W, write address, port A.
- writeDataA, in, DATA_W, write data, port A.
- byteEnA, in, DATA_W/8, byte lane enables, port A.
- regWriteB, in, 1, write enable, port B.
- destRegB, in, ADDR_W, write address, port B.
- writeDataB, in, DATA_W, write data, port B.
- byteEnB, in, DATA_W/8, byte lane enables, port B.
- srcRegA, in, ADDR_W, read address, bus A.
- srcRegB, in, ADDR_W, read address, bus B.
- outBusA, out, DATA_W, read data, bus A.
- outBusB, out, DATA_W, read data, bus B.

Function
REQ-003 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-004 On a rising edge with RST=0 and regWriteX=1, each lane i of destRegX with byteEnX[i]=1 SHALL take writeDataX lane i; lanes with byteEnX[i]=0 SHALL hold their value.
REQ-005 Writes on both ports to the same address SHALL merge per lane; where both ports enable a lane, port B's data SHALL win.
REQ-006 Writes on both ports to different addresses SHALL both complete in the same cycle.
REQ-007 With ZERO_REG=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return 0, including under bypass.
REQ-008 With READ_LAT=0, outBusX SHALL combinationally reflect the contents of srcRegX.
REQ-009 With READ_LAT=1, outBusX SHALL be registered: the value visible after edge N SHALL be the contents of srcRegX sampled at edge N.
REQ-010 With BYPASS=1 and READ_LAT=0, a read address matching an active write address in the same cycle SHALL return the post-write merged value, computed by REQ-004/005 rules.
REQ-011 With BYPASS=1 and READ_LAT=1, the registered output SHALL capture the post-write merged value at the same edge as the write.
REQ-012 With BYPASS=0, a same-cycle matching read SHALL return the pre-write value; the new value SHALL be visible from the next cycle (READ_LAT=0) or from one cycle after the next edge (READ_LAT=1).
REQ-013 Both read buses SHALL be independent; identical addresses SHALL return identical data.
REQ-014 A write with regWriteX=1 and byteEnX all zero SHALL leave storage unchanged.

Reset
REQ-015 At a rising edge with RST=1, all registers SHALL clear to 0 and, if READ_LAT=1, outBusA/outBusB SHALL clear to 0.
REQ-016 Reset SHALL take priority over same-cycle writes; those writes SHALL be dropped and SHALL NOT be bypassed.
REQ-017 Reset asserted mid-sequence SHALL clear everything within one edge; the first edge with RST=0 SHALL accept writes normally.

Verification
REQ-018 The bench SHALL cover these scenarios (defaults unless noted):
- Reset, then write regs 1..7 with values 7..1 via port A (byteEn=4'hF), read pairs (7,6), (5,4), (3,2), (1,0) -> outputs 1,2 / 3,4 / 5,6 / 7,0.
- Reg 3 = 32'h11223344; port A writes 32'hAAAAAAAA with byteEn 4'b0011 and port B writes 32'hBBBBBBBB with byteEn 4'b0110, both to reg 3 -> reg 3 = 32'h11BBBBAA.
- BYPASS=1: write reg 5 = 32'hDEADBEEF while srcRegA=5 -> outBusA=32'hDEADBEEF in the same cycle. BYPASS=0: outBusA shows the old value until the next cycle.
- Write 32'hFFFFFFFF to reg 0 with ZERO_REG=1 -> reg 0 reads 0 on both buses, including the bypass path.
- READ_LAT=1: write reg 2 = 9 at edge N, srcRegB=2 -> outBusB=9 after edge N with BYPASS=1, or after edge N+1 with BYPASS=0.
- With regs loaded, assert RST together with a write of 5 to reg 4 -> after the edge all registers and outputs read 0; reg 4 is not 5.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp -- multi-ported register file.
//   Two write ports (A, B) with per-byte lane enables and two independent
//   read buses. Same-address writes merge per lane (port B wins a lane that
//   both ports enable). Optional hard-wired zero register, optional
//   same-cycle write-to-read forwarding, and optional registered reads.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   regWriteA/destRegA/writeDataA/byteEnA   write port A
//   regWriteB/destRegB/writeDataB/byteEnB   write port B
//   srcRegA/srcRegB               read addresses
//   outBusA/outBusB               read data

// Byte-lane merge: the next value of one byte given both write ports.
module register_file_mp_lane (
    input  logic [7:0] hold,
    input  logic       a_en,
    input  logic [7:0] a_d,
    input  logic       b_en,
    input  logic [7:0] b_d,
    output logic [7:0] q
);
    assign q = b_en ? b_d : (a_en ? a_d : hold);
endmodule

module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                regWriteA,
    input  logic [ADDR_W-1:0]   destRegA,
    input  logic [DATA_W-1:0]   writeDataA,
    input  logic [DATA_W/8-1:0] byteEnA,
    input  logic                regWriteB,
    input  logic [ADDR_W-1:0]   destRegB,
    input  logic [DATA_W-1:0]   writeDataB,
    input  logic [DATA_W/8-1:0] byteEnB,
    input  logic [ADDR_W-1:0]   srcRegA,
    input  logic [ADDR_W-1:0]   srcRegB,
    output logic [DATA_W-1:0]   outBusA,
    output logic [DATA_W-1:0]   outBusB
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic [DEPTH-1:0][LANES-1:0][7:0] regs_q;
    logic [DEPTH-1:0][LANES-1:0][7:0] regs_d;

    // Writes presented during reset are dropped, so they must not be
    // forwarded to the read buses either.
    logic wr_a, wr_b;
    assign wr_a = regWriteA & ~RST;
    assign wr_b = regWriteB & ~RST;

    // Next-state for every register, lane by lane.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if (ZERO_REG != 0 && r == 0) begin : g_zero
            assign regs_d[r] = '0;
        end else begin : g_data
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                register_file_mp_lane u_lane (
                    .hold (regs_q[r][l]),
                    .a_en (wr_a && destRegA == ADDR_W'(r) && byteEnA[l]),
                    .a_d  (writeDataA[l*8 +: 8]),
                    .b_en (wr_b && destRegB == ADDR_W'(r) && byteEnB[l]),
                    .b_d  (writeDataB[l*8 +: 8]),
                    .q    (regs_d[r][l])
                );
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) regs_q <= '0;
        else     regs_q <= regs_d;
    end

    // Read buses: index 0 = bus A, index 1 = bus B.
    logic [1:0][ADDR_W-1:0] src;
    logic [1:0][DATA_W-1:0] rd_val;
    assign src = {srcRegB, srcRegA};

    for (genvar b = 0; b < 2; b++) begin : g_rd
        logic [LANES-1:0][7:0] cur;
        logic [LANES-1:0][7:0] sel;
        assign cur = regs_q[src[b]];

        if (BYPASS != 0) begin : g_byp
            // Same merge rule as storage, applied to the addressed register,
            // so the forwarded value is exactly what will be written.
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                register_file_mp_lane u_lane (
                    .hold (cur[l]),
                    .a_en (wr_a && destRegA == src[b] && byteEnA[l]),
                    .a_d  (writeDataA[l*8 +: 8]),
                    .b_en (wr_b && destRegB == src[b] && byteEnB[l]),
                    .b_d  (writeDataB[l*8 +: 8]),
                    .q    (sel[l])
                );
            end
        end else begin : g_nobyp
            assign sel = cur;
        end

        // Forwarding would otherwise leak writes to register 0.
        if (ZERO_REG != 0) begin : g_z
            assign rd_val[b] = (src[b] == '0) ? '0 : sel;
        end else begin : g_nz
            assign rd_val[b] = sel;
        end
    end

    if (READ_LAT == 0) begin : g_comb
        assign outBusA = rd_val[0];
        assign outBusB = rd_val[1];
    end else begin : g_reg_out
        always_ff @(posedge CLK) begin
            if (RST) begin
                outBusA <= '0;
                outBusB <= '0;
            end else begin
                outBusA <= rd_val[0];
                outBusB <= rd_val[1];
            end
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: four instances share one stimulus stream,
// covering the BYPASS x READ_LAT combinations.
//   d0: BYPASS=1 READ_LAT=0   d1: BYPASS=0 READ_LAT=0
//   d2: BYPASS=1 READ_LAT=1   d3: BYPASS=0 READ_LAT=1
module tb_register_file_mp;
    logic        CLK = 1'b0;
    logic        RST;
    logic        regWriteA, regWriteB;
    logic [2:0]  destRegA, destRegB, srcRegA, srcRegB;
    logic [31:0] writeDataA, writeDataB;
    logic [3:0]  byteEnA, byteEnB;
    logic [31:0] oa0, ob0, oa1, ob1, oa2, ob2, oa3, ob3;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    register_file_mp #(.BYPASS(1), .READ_LAT(0)) d0 (
        .CLK(CLK), .RST(RST),
        .regWriteA(regWriteA), .destRegA(destRegA), .writeDataA(writeDataA), .byteEnA(byteEnA),
        .regWriteB(regWriteB), .destRegB(destRegB), .writeDataB(writeDataB), .byteEnB(byteEnB),
        .srcRegA(srcRegA), .srcRegB(srcRegB), .outBusA(oa0), .outBusB(ob0));
    register_file_mp #(.BYPASS(0), .READ_LAT(0)) d1 (
        .CLK(CLK), .RST(RST),
        .regWriteA(regWriteA), .destRegA(destRegA), .writeDataA(writeDataA), .byteEnA(byteEnA),
        .regWriteB(regWriteB), .destRegB(destRegB), .writeDataB(writeDataB), .byteEnB(byteEnB),
        .srcRegA(srcRegA), .srcRegB(srcRegB), .outBusA(oa1), .outBusB(ob1));
    register_file_mp #(.BYPASS(1), .READ_LAT(1)) d2 (
        .CLK(CLK), .RST(RST),
        .regWriteA(regWriteA), .destRegA(destRegA), .writeDataA(writeDataA), .byteEnA(byteEnA),
        .regWriteB(regWriteB), .destRegB(destRegB), .writeDataB(writeDataB), .byteEnB(byteEnB),
        .srcRegA(srcRegA), .srcRegB(srcRegB), .outBusA(oa2), .outBusB(ob2));
    register_file_mp #(.BYPASS(0), .READ_LAT(1)) d3 (
        .CLK(CLK), .RST(RST),
        .regWriteA(regWriteA), .destRegA(destRegA), .writeDataA(writeDataA), .byteEnA(byteEnA),
        .regWriteB(regWriteB), .destRegB(destRegB), .writeDataB(writeDataB), .byteEnB(byteEnB),
        .srcRegA(srcRegA), .srcRegB(srcRegB), .outBusA(oa3), .outBusB(ob3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        regWriteA = 0; regWriteB = 0;
        byteEnA = 4'hF; byteEnB = 4'hF;
        destRegA = 0; destRegB = 0;
        writeDataA = 0; writeDataB = 0;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        regWriteA = 1; destRegA = a; writeDataA = d; byteEnA = be;
    endtask

    task automatic wr_b(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        regWriteB = 1; destRegB = a; writeDataB = d; byteEnB = be;
    endtask

    logic [2:0]  pa [4] = '{3'd7, 3'd5, 3'd3, 3'd1};
    logic [2:0]  pb [4] = '{3'd6, 3'd4, 3'd2, 3'd0};
    logic [31:0] ea [4] = '{32'd1, 32'd3, 32'd5, 32'd7};
    logic [31:0] eb [4] = '{32'd2, 32'd4, 32'd6, 32'd0};

    initial begin
        idle();
        RST = 1; srcRegA = 3; srcRegB = 5;
        tick(); tick();
        RST = 0;
        #1;
        chk("rst_comb_a", oa0, 0);
        chk("rst_comb_b", ob0, 0);
        chk("rst_reg_a", oa2, 0);
        chk("rst_reg_b", ob3, 0);

        // regs 1..7 = 7..1 via port A
        for (int r = 1; r < 8; r++) begin
            wr_a(3'(r), 32'(8 - r), 4'hF);
            tick();
        end
        idle();

        for (int i = 0; i < 4; i++) begin
            srcRegA = pa[i]; srcRegB = pb[i];
            #1;
            chk("pair_comb_a", oa0, ea[i]);
            chk("pair_comb_b", ob0, eb[i]);
            tick();
            chk("pair_lat_a", oa2, ea[i]);
            chk("pair_lat_b", ob3, eb[i]);
        end

        // Lane merge with port B priority
        wr_a(3, 32'h11223344, 4'hF);
        tick();
        wr_a(3, 32'hAAAAAAAA, 4'b0011);
        wr_b(3, 32'hBBBBBBBB, 4'b0110);
        srcRegA = 3;
        #1;
        chk("merge_byp", oa0, 32'h11BBBBAA);
        chk("merge_nobyp", oa1, 32'h11223344);
        tick();
        idle();
        #1;
        chk("merge_store", oa1, 32'h11BBBBAA);

        // Different addresses in one cycle
        wr_a(1, 32'h100, 4'hF);
        wr_b(2, 32'h200, 4'hF);
        tick();
        idle();
        srcRegA = 1; srcRegB = 2;
        #1;
        chk("dual_a", oa1, 32'h100);
        chk("dual_b", ob1, 32'h200);

        // Enable with no lanes leaves reg 4 untouched
        wr_a(4, 32'hFFFFFFFF, 4'h0);
        srcRegA = 4;
        #1;
        chk("be0_byp", oa0, 32'd4);
        tick();
        idle();
        #1;
        chk("be0_store", oa1, 32'd4);

        // Same-cycle forwarding vs. not
        srcRegA = 5;
        wr_a(5, 32'hDEADBEEF, 4'hF);
        #1;
        chk("byp_new", oa0, 32'hDEADBEEF);
        chk("nobyp_old", oa1, 32'd3);
        tick();
        idle();
        #1;
        chk("nobyp_next", oa1, 32'hDEADBEEF);

        // Register 0 stays zero, forwarding included
        srcRegA = 0; srcRegB = 0;
        wr_a(0, 32'hFFFFFFFF, 4'hF);
        wr_b(0, 32'hFFFFFFFF, 4'hF);
        #1;
        chk("zero_byp_a", oa0, 0);
        chk("zero_byp_b", ob0, 0);
        tick();
        chk("zero_lat_a", oa2, 0);
        idle();
        #1;
        chk("zero_store_a", oa1, 0);
        chk("zero_store_b", ob1, 0);

        // Registered reads: write reg 2 = 9 at edge N
        srcRegB = 2;
        wr_a(2, 32'd9, 4'hF);
        tick();
        idle();
        chk("lat_byp_n", ob2, 32'd9);
        chk("lat_nobyp_n", ob3, 32'h200);
        tick();
        chk("lat_nobyp_n1", ob3, 32'd9);

        // Reset beats a same-cycle write
        srcRegA = 4; srcRegB = 7;
        wr_a(4, 32'd5, 4'hF);
        RST = 1;
        tick();
        RST = 0;
        idle();
        chk("rstw_lat_a", oa2, 0);
        chk("rstw_lat_b", ob2, 0);
        chk("rstw_lat3_a", oa3, 0);
        for (int r = 0; r < 8; r++) begin
            srcRegA = 3'(r);
            #1;
            chk("rstw_clear", oa1, 0);
        end

        // First edge after reset writes normally
        wr_a(6, 32'h66, 4'hF);
        tick();
        idle();
        srcRegA = 6;
        #1;
        chk("post_rst_wr", oa1, 32'h66);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
